// File: rtl/i2c_eeprom_arbiter_if.sv
// Client-side request/response and master-side descriptor/handshake bundle for i2c_eeprom_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface i2c_eeprom_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 256
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*7-1:0]      req_dev;
  logic [NUM_REQ*16-1:0]     req_mem;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [1:0]                rsp_status;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      m_enable;
  logic                      m_rw;
  logic [6:0]                m_addr;
  logic [7:0]                m_port_f;
  logic [7:0]                m_port_s;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_rst_n;
  logic                      m_done;
  logic                      m_err;
  logic [DATA_W-1:0]         m_rdata;

  modport slave (
    input  req, req_rw, req_dev, req_mem, req_wdata, m_done, m_err, m_rdata,
    output grant, rsp_valid, rsp_status, rsp_rdata,
    output m_enable, m_rw, m_addr, m_port_f, m_port_s, m_wdata, m_rst_n
  );

  modport master (
    output req, req_rw, req_dev, req_mem, req_wdata, m_done, m_err, m_rdata,
    input  grant, rsp_valid, rsp_status, rsp_rdata,
    input  m_enable, m_rw, m_addr, m_port_f, m_port_s, m_wdata, m_rst_n
  );
endinterface

// File: rtl/i2c_eeprom_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM page master among NUM_REQ clients, with
// descriptor latching, NACK retry and timeout recovery via a master reset pulse.
module i2c_eeprom_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned XFER_TIMEOUT  = 65535
) (
  input logic                 clk,
  input logic                 reset,
  i2c_eeprom_arbiter_if.slave bus
);
  localparam int unsigned PW   = $clog2(NUM_REQ);
  localparam int unsigned RW   = $clog2(MAX_RETRY + 2);
  localparam int unsigned TMAX = (XFER_TIMEOUT > START_TIMEOUT) ? XFER_TIMEOUT : START_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitDone, StResp, StRecover, StGap} state_e;

  state_e              r_state;
  logic [PW-1:0]       r_rr;
  logic [PW-1:0]       r_owner;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [1:0]          r_status;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_m_enable;
  logic                r_m_rw;
  logic [6:0]          r_m_addr;
  logic [7:0]          r_m_port_f;
  logic [7:0]          r_m_port_s;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                r_m_rst_n;
  logic [RW-1:0]       r_retry;
  logic [TW-1:0]       r_timer;

  logic                w_found;
  logic [PW-1:0]       w_pick;
  logic [PW:0]         w_slot;

  // First requester at or after the round-robin pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_slot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slot = {1'b0, r_rr} + (PW+1)'(i);
      if (w_slot >= (PW+1)'(NUM_REQ)) w_slot = w_slot - (PW+1)'(NUM_REQ);
      if (!w_found && bus.req[w_slot[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_slot[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_rr        <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_status    <= 2'b00;
      r_rsp_rdata <= '0;
      r_m_enable  <= 1'b0;
      r_m_rw      <= 1'b0;
      r_m_addr    <= '0;
      r_m_port_f  <= '0;
      r_m_port_s  <= '0;
      r_m_wdata   <= '0;
      r_m_rst_n   <= 1'b1;
      r_retry     <= '0;
      r_timer     <= '0;
    end else begin
      r_rsp_valid <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_owner    <= w_pick;
            r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
            r_m_rw     <= bus.req_rw[w_pick];
            r_m_addr   <= bus.req_dev[w_pick*7 +: 7];
            r_m_port_f <= bus.req_mem[w_pick*16+8 +: 8];
            r_m_port_s <= bus.req_mem[w_pick*16 +: 8];
            r_m_wdata  <= bus.req_wdata[w_pick*DATA_W +: DATA_W];
            r_m_enable <= 1'b1;
            r_timer    <= '0;
            r_state    <= StLaunch;
          end
        end
        StLaunch: begin
          if (!bus.m_done) begin
            r_m_enable <= 1'b0;
            r_timer    <= '0;
            r_state    <= StWaitDone;
          end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
            r_m_enable <= 1'b0;
            r_status   <= 2'b10;
            r_m_rst_n  <= 1'b0;
            r_timer    <= '0;
            r_state    <= StRecover;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StWaitDone: begin
          if (bus.m_done) begin
            if (bus.m_err && (r_retry < RW'(MAX_RETRY))) begin
              r_retry <= r_retry + 1'b1;
              r_state <= StGap;
            end else begin
              if (bus.m_err) begin
                r_status <= 2'b01;
              end else begin
                r_status <= 2'b00;
                if (r_m_rw) r_rsp_rdata <= bus.m_rdata;
              end
              r_rsp_valid <= r_grant;
              r_state     <= StResp;
            end
          end else if (r_timer == TW'(XFER_TIMEOUT - 1)) begin
            r_status  <= 2'b10;
            r_m_rst_n <= 1'b0;
            r_timer   <= '0;
            r_state   <= StRecover;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StGap: begin
          r_m_enable <= 1'b1;
          r_timer    <= '0;
          r_state    <= StLaunch;
        end
        // Master reset held low two cycles, then released two cycles before responding.
        StRecover: begin
          r_timer <= r_timer + 1'b1;
          if (r_timer == TW'(1)) r_m_rst_n <= 1'b1;
          if (r_timer == TW'(3)) begin
            r_rsp_valid <= r_grant;
            r_state     <= StResp;
          end
        end
        StResp: begin
          r_grant <= '0;
          r_rr    <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
          r_retry <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.grant      = r_grant;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_status;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.m_enable   = r_m_enable;
  assign bus.m_rw       = r_m_rw;
  assign bus.m_addr     = r_m_addr;
  assign bus.m_port_f   = r_m_port_f;
  assign bus.m_port_s   = r_m_port_s;
  assign bus.m_wdata    = r_m_wdata;
  assign bus.m_rst_n    = r_m_rst_n;
endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// Scoreboard bench for i2c_eeprom_arbiter with a small behavioural page-master model
// covering arbitration order, read capture, NACK retry, start timeout and async reset.
module tb_i2c_eeprom_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 256;

  typedef struct {
    int                client;
    logic [1:0]        status;
    logic [DATA_W-1:0] rdata;
    bit                chk_rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  i2c_eeprom_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  i2c_eeprom_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .MAX_RETRY    (3),
    .START_TIMEOUT(64),
    .XFER_TIMEOUT (65535)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t              sb[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [DATA_W-1:0] exp_rdata = '0;

  bit                mdl_hang = 1'b0;
  bit                mdl_err_all = 1'b0;
  bit                mdl_err_first = 1'b0;
  int                mdl_base = 0;
  logic [DATA_W-1:0] mdl_rdata = '0;
  int                launches = 0;

  // Page master: accepts m_enable when idle, busy for 3 cycles, then done with optional err.
  initial begin
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt = 0;
    bus.m_done = 1'b1;
    bus.m_err = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      if (!bus.m_rst_n) begin
        busy = 1'b0;
        #1 bus.m_done = 1'b1;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          #1;
          bus.m_err = mdl_err_all || (mdl_err_first && (launches == mdl_base + 1));
          bus.m_rdata = mdl_rdata;
          bus.m_done = 1'b1;
        end
      end else if (bus.m_enable && !mdl_hang) begin
        launches++;
        busy = 1'b1;
        cnt = 3;
        #1;
        bus.m_done = 1'b0;
        bus.m_err = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_client(input int c, input bit rw, input logic [6:0] dev,
                            input logic [15:0] mem, input logic [DATA_W-1:0] wd);
    bus.req_rw[c]                 = rw;
    bus.req_dev[c*7 +: 7]         = dev;
    bus.req_mem[c*16 +: 16]       = mem;
    bus.req_wdata[c*DATA_W +: DATA_W] = wd;
  endtask

  task automatic push(input int c, input logic [1:0] st, input bit chk);
    sb.push_back('{client: c, status: st, rdata: exp_rdata, chk_rd: chk});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    exp_rdata = '0;
  endtask

  // Called at a negedge; returns at the negedge after the response pulse.
  task automatic wait_rsp();
    int   n;
    exp_t e;
    n = 0;
    while (!(|bus.rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(|bus.rsp_valid)) begin
      check_eq("rsp_wait", bus.rsp_valid, 1);
      return;
    end
    if (sb.size() == 0) begin
      check_eq("rsp_unexpected", bus.rsp_valid, 0);
      return;
    end
    e = sb.pop_front();
    check_eq("rsp_owner", bus.rsp_valid, 1 << e.client);
    check_eq("grant_owner", bus.grant, 1 << e.client);
    check_eq("rsp_status", bus.rsp_status, e.status);
    if (e.chk_rd) check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
    bus.req = bus.req & ~bus.rsp_valid;
    @(negedge clk);
    check_eq("rsp_pulse", bus.rsp_valid, 0);
    check_eq("grant_clr", bus.grant, 0);
  endtask

  initial begin
    int n;
    int cnt;
    bus.req = '0;
    bus.req_rw = '0;
    bus.req_dev = '0;
    bus.req_mem = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_status", bus.rsp_status, 0);
    check_eq("rst_rdata", bus.rsp_rdata, 0);
    check_eq("rst_enable", bus.m_enable, 0);
    check_eq("rst_m_rst_n", bus.m_rst_n, 1);
    check_eq("rst_m_addr", bus.m_addr, 0);
    check_eq("rst_m_wdata", bus.m_wdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single write from client 1
    set_client(1, 1'b0, 7'h50, 16'h0012, {8{32'hDEADBEEF}});
    bus.req = 4'b0010;
    push(1, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    check_eq("t1_grant", bus.grant, 4'b0010);
    check_eq("t1_enable", bus.m_enable, 1);
    check_eq("t1_rw", bus.m_rw, 0);
    check_eq("t1_addr", bus.m_addr, 7'h50);
    check_eq("t1_port_f", bus.m_port_f, 8'h00);
    check_eq("t1_port_s", bus.m_port_s, 8'h12);
    check_eq("t1_wdata", bus.m_wdata, {8{32'hDEADBEEF}});
    n = 0;
    while (bus.m_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t1_done_fall", bus.m_done, 0);
    @(negedge clk);
    check_eq("t1_enable_drop", bus.m_enable, 0);
    wait_rsp();

    // Contention from reset, then client 0 re-requests
    do_reset();
    for (int c = 0; c < NUM_REQ; c++) set_client(c, 1'b0, 7'h50 + 7'(c), 16'(c * 16'h0101), '0);
    bus.req = 4'b1111;
    for (int c = 0; c < NUM_REQ; c++) push(c, 2'b00, 1'b1);
    wait_rsp();
    bus.req[0] = 1'b1;
    push(0, 2'b00, 1'b1);
    for (int k = 0; k < 4; k++) wait_rsp();

    // Read capture, then held across a later write
    mdl_rdata = {32{8'hA5}};
    set_client(2, 1'b1, 7'h51, 16'h0340, '0);
    bus.req = 4'b0100;
    exp_rdata = {32{8'hA5}};
    push(2, 2'b00, 1'b1);
    wait_rsp();
    mdl_rdata = {DATA_W{1'b1}};
    set_client(3, 1'b0, 7'h52, 16'h0800, {8{32'h12345678}});
    bus.req = 4'b1000;
    push(3, 2'b00, 1'b1);
    wait_rsp();
    check_eq("t3_rdata_hold", bus.rsp_rdata, {32{8'hA5}});

    // NACK on every attempt, then only on the first
    mdl_err_all = 1'b1;
    mdl_base = launches;
    set_client(0, 1'b0, 7'h53, 16'h0001, '0);
    bus.req = 4'b0001;
    push(0, 2'b01, 1'b1);
    wait_rsp();
    check_eq("t4_nack_launches", launches - mdl_base, 4);
    mdl_err_all = 1'b0;
    mdl_err_first = 1'b1;
    mdl_base = launches;
    set_client(1, 1'b1, 7'h54, 16'h0002, '0);
    mdl_rdata = {32{8'h3C}};
    exp_rdata = {32{8'h3C}};
    bus.req = 4'b0010;
    push(1, 2'b00, 1'b1);
    wait_rsp();
    check_eq("t4_retry_launches", launches - mdl_base, 2);
    mdl_err_first = 1'b0;

    // Start timeout: master never answers client 1; client 2 served afterwards
    do_reset();
    mdl_hang = 1'b1;
    set_client(1, 1'b0, 7'h55, 16'h0010, '0);
    set_client(2, 1'b0, 7'h56, 16'h0020, '0);
    bus.req = 4'b0110;
    push(1, 2'b10, 1'b1);
    push(2, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    cnt = 0;
    n = 0;
    while (bus.m_rst_n && n < 200) begin
      @(negedge clk);
      if (bus.m_enable) cnt++;
      n++;
    end
    check_eq("t5_start_cycles", cnt, 64);
    mdl_hang = 1'b0;
    cnt = 0;
    n = 0;
    while (!bus.m_rst_n && n < 10) begin
      cnt++;
      @(negedge clk);
      n++;
    end
    check_eq("t5_rst_low", cnt, 2);
    cnt = 0;
    n = 0;
    while (!(|bus.rsp_valid) && n < 10) begin
      cnt++;
      @(negedge clk);
      n++;
    end
    check_eq("t5_rst_high", cnt, 2);
    wait_rsp();
    wait_rsp();

    // Async reset in the middle of a transfer
    set_client(2, 1'b0, 7'h57, 16'h0030, '0);
    bus.req = 4'b0100;
    push(2, 2'b00, 1'b1);
    wait_rsp();
    set_client(3, 1'b0, 7'h58, 16'h0040, '0);
    bus.req = 4'b1000;
    n = 0;
    while (bus.m_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("t6_in_wait", {bus.m_done, bus.m_enable}, 2'b00);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_grant", bus.grant, 0);
    check_eq("t6_enable", bus.m_enable, 0);
    check_eq("t6_rsp_valid", bus.rsp_valid, 0);
    check_eq("t6_m_rst_n", bus.m_rst_n, 1);
    check_eq("t6_m_addr", bus.m_addr, 0);
    bus.req = '0;
    @(negedge clk);
    reset = 1'b1;
    exp_rdata = '0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (|bus.rsp_valid) cnt++;
    end
    check_eq("t6_no_rsp", cnt, 0);
    set_client(0, 1'b0, 7'h59, 16'h0050, '0);
    bus.req = 4'b1001;
    push(0, 2'b00, 1'b1);
    push(3, 2'b00, 1'b1);
    wait_rsp();
    wait_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
